sd_read_monitor: RTL and testbench

Measurement stage directly downstream of the SD-over-SPI read test system. It watches the byte stream the SD read path delivers, together with that system's `start`/`finish` handshake. It reports elapsed clock cycles, bytes received, completed blocks, a length-error flag and an optional data checksum, so throughput for a given `sclk_speed`/`cmd18` setting can be read back by the measurement host.

---
 rtl/sd_read_monitor_pkg.sv | 18 +
 rtl/sd_read_monitor_if.sv | 38 +++
 rtl/sd_mon_block_counter.sv | 37 +++
 rtl/sd_read_monitor.sv | 122 ++++++++++++
 tb/tb_sd_read_monitor.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_read_monitor_pkg.sv
// Shared types and defaults for the SD read throughput monitor.
package sd_read_monitor_pkg;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2
  } mon_state_t;

  localparam int DEF_BLOCK_BYTES = 512;
  localparam int DEF_CNT_W       = 32;

  // Rotate-left-by-one then add the byte, mod 2^32.
  function automatic logic [31:0] csum_step(input logic [31:0] c, input logic [7:0] d);
    return {c[30:0], c[31]} + {24'h0, d};
  endfunction

endpackage

// File: rtl/sd_read_monitor_if.sv
// Monitor bus: run handshake and byte stream in, measurement results out.
// The checksum member exists only with SD_READ_MONITOR_CHECKSUM_EN defined.
interface sd_read_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             finish;
  logic [31:0]      n_blocks;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] bytes;
  logic [CNT_W-1:0] blocks;
  logic             cyc_ovf;
  logic             len_err;
`ifdef SD_READ_MONITOR_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  modport master (
    output start, finish, n_blocks, byte_valid, byte_data,
    input  busy, done, cycles, bytes, blocks, cyc_ovf, len_err
`ifdef SD_READ_MONITOR_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  start, finish, n_blocks, byte_valid, byte_data,
    output busy, done, cycles, bytes, blocks, cyc_ovf, len_err
`ifdef SD_READ_MONITOR_CHECKSUM_EN
    , output checksum
`endif
  );

endinterface

// File: rtl/sd_mon_block_counter.sv
// Byte-in-block index modulo BLOCK_BYTES plus completed-block counter.
// Count visible one edge after inc; wrap is a same-cycle pulse on the last byte of a block.
module sd_mon_block_counter #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] blocks,
  output logic             wrap
);
  localparam int IDX_W = $clog2(BLOCK_BYTES);

  logic [IDX_W-1:0] idx;

  assign wrap = inc && (idx == IDX_W'(BLOCK_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      blocks <= '0;
    end else if (clr) begin
      idx    <= '0;
      blocks <= '0;
    end else if (inc) begin
      if (wrap) begin
        idx    <= '0;
        blocks <= blocks + 1'b1;
      end else begin
        idx    <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_read_monitor.sv
// Measures one SD read run: cycles in RUN, bytes, blocks and a length check; all outputs
// registered. Optional rolling checksum with SD_READ_MONITOR_CHECKSUM_EN defined.
module sd_read_monitor
  import sd_read_monitor_pkg::*;
#(
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  sd_read_monitor_if.slave mon
);
  localparam int BLK_SH = $clog2(BLOCK_BYTES);

  mon_state_t           state;
  mon_state_t           state_nxt;
  logic                 accept_start;
  logic                 byte_inc;
  logic                 busy_q;
  logic                 done_q;
  logic                 cyc_ovf_q;
  logic                 len_err_q;
  logic [CNT_W-1:0]     cycles_q;
  logic [CNT_W-1:0]     bytes_q;
  logic [CNT_W-1:0]     bytes_nxt;
  logic [CNT_W-1:0]     exp_bytes;
  logic [CNT_W-1:0]     blocks;
  logic [31:0]          nblk_q;
  logic [31+BLK_SH:0]   nblk_sh;
  logic                 blk_wrap_unused;

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      MON_IDLE, MON_DONE: begin
        if (mon.start) begin
          state_nxt    = MON_RUN;
          accept_start = 1'b1;
        end
      end
      MON_RUN: begin
        if (mon.finish) state_nxt = MON_DONE;
      end
      default: state_nxt = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MON_IDLE;
    else      state <= state_nxt;
  end

  assign byte_inc  = (state == MON_RUN) && mon.byte_valid;
  assign bytes_nxt = bytes_q + CNT_W'(byte_inc);
  assign nblk_sh   = {nblk_q, {BLK_SH{1'b0}}};
  assign exp_bytes = CNT_W'(nblk_sh);

  // The finishing edge still counts its cycle and any coincident byte before freezing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cycles_q  <= '0;
      bytes_q   <= '0;
      cyc_ovf_q <= 1'b0;
      len_err_q <= 1'b0;
      nblk_q    <= '0;
    end else begin
      busy_q <= (state_nxt == MON_RUN);
      done_q <= (state_nxt == MON_DONE);
      if (accept_start) begin
        cycles_q  <= '0;
        bytes_q   <= '0;
        cyc_ovf_q <= 1'b0;
        len_err_q <= 1'b0;
        nblk_q    <= mon.n_blocks;
      end else if (state == MON_RUN) begin
        if (cycles_q == {CNT_W{1'b1}}) cyc_ovf_q <= 1'b1;
        else                           cycles_q  <= cycles_q + 1'b1;
        bytes_q <= bytes_nxt;
        if (mon.finish) len_err_q <= (bytes_nxt != exp_bytes);
      end
    end
  end

  sd_mon_block_counter #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .CNT_W       (CNT_W)
  ) u_blk (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_start),
    .inc    (byte_inc),
    .blocks (blocks),
    .wrap   (blk_wrap_unused)
  );

`ifdef SD_READ_MONITOR_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              csum_q <= '0;
    else if (accept_start) csum_q <= '0;
    else if (byte_inc)     csum_q <= csum_step(csum_q, mon.byte_data);
  end

  assign mon.checksum = csum_q;
`else
  logic [7:0] byte_data_unused;
  assign byte_data_unused = mon.byte_data;
`endif

  assign mon.busy    = busy_q;
  assign mon.done    = done_q;
  assign mon.cycles  = cycles_q;
  assign mon.bytes   = bytes_q;
  assign mon.blocks  = blocks;
  assign mon.cyc_ovf = cyc_ovf_q;
  assign mon.len_err = len_err_q;

endmodule

// File: tb/tb_sd_read_monitor.sv
// Drives two monitors (512-byte blocks / 32-bit counters and 4-byte blocks / 8-bit counters)
// with the same directed runs; results are scoreboarded when done rises.
module tb_sd_read_monitor;

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] blocks;
    logic [31:0] cycles;
    logic        ovf;
    logic        lerr;
    logic [31:0] cks;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s;
  logic        fin_s;
  logic [31:0] nb_s;
  logic        bv_s;
  logic [7:0]  bd_s;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t q32[$];
  exp_t q8[$];
  logic prev_done32 = 1'b0;
  logic prev_done8  = 1'b0;

  always #5 clk = ~clk;

  sd_read_monitor_if #(.CNT_W(32)) bus ();
  sd_read_monitor_if #(.CNT_W(8))  bus8 ();

  assign bus.start       = start_s;
  assign bus.finish      = fin_s;
  assign bus.n_blocks    = nb_s;
  assign bus.byte_valid  = bv_s;
  assign bus.byte_data   = bd_s;
  assign bus8.start      = start_s;
  assign bus8.finish     = fin_s;
  assign bus8.n_blocks   = nb_s;
  assign bus8.byte_valid = bv_s;
  assign bus8.byte_data  = bd_s;

  sd_read_monitor #(.BLOCK_BYTES(512), .CNT_W(32)) dut (.clk(clk), .rst(rst), .mon(bus));
  sd_read_monitor #(.BLOCK_BYTES(4),   .CNT_W(8))  dut8 (.clk(clk), .rst(rst), .mon(bus8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] by, input logic [31:0] bl, input logic [31:0] cy,
                              input logic ov, input logic le, input logic [31:0] ck);
    exp_t e;
    e.bytes = by; e.blocks = bl; e.cycles = cy; e.ovf = ov; e.lerr = le; e.cks = ck;
    return e;
  endfunction

  task automatic check_res(input string tag, input exp_t e, input logic [31:0] by,
                           input logic [31:0] bl, input logic [31:0] cy, input logic ov,
                           input logic le, input logic bz);
    chk({tag, "_bytes"},   by,       e.bytes);
    chk({tag, "_blocks"},  bl,       e.blocks);
    chk({tag, "_cycles"},  cy,       e.cycles);
    chk({tag, "_cyc_ovf"}, 32'(ov),  32'(e.ovf));
    chk({tag, "_len_err"}, 32'(le),  32'(e.lerr));
    chk({tag, "_busy"},    32'(bz),  32'd0);
  endtask

  // Scoreboard monitors: compare on each rising edge of done.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && !prev_done32) begin
      if (q32.size() == 0) begin
        n_checks++; n_fails++;
        $display("FAIL w32_unexpected_done: got done=1, expected no result pending");
      end else begin
        e = q32.pop_front();
        check_res("w32", e, bus.bytes, bus.blocks, bus.cycles, bus.cyc_ovf, bus.len_err, bus.busy);
`ifdef SD_READ_MONITOR_CHECKSUM_EN
        chk("w32_checksum", bus.checksum, e.cks);
`endif
      end
    end
    prev_done32 = bus.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus8.done && !prev_done8) begin
      if (q8.size() == 0) begin
        n_checks++; n_fails++;
        $display("FAIL w8_unexpected_done: got done=1, expected no result pending");
      end else begin
        e = q8.pop_front();
        check_res("w8", e, 32'(bus8.bytes), 32'(bus8.blocks), 32'(bus8.cycles),
                  bus8.cyc_ovf, bus8.len_err, bus8.busy);
`ifdef SD_READ_MONITOR_CHECKSUM_EN
        chk("w8_checksum", bus8.checksum, e.cks);
`endif
      end
    end
    prev_done8 = bus8.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [31:0] nb);
    nb_s    = nb;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    bv_s = 1'b1;
    bd_s = d;
    tick();
    bv_s = 1'b0;
    bd_s = 8'h00;
  endtask

  task automatic end_run(input exp_t e32, input exp_t e8);
    q32.push_back(e32);
    q8.push_back(e8);
    fin_s = 1'b1;
    tick();
    fin_s = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_cycles"},  bus.cycles,       32'd0);
    chk({tag, "_bytes"},   bus.bytes,        32'd0);
    chk({tag, "_blocks"},  bus.blocks,       32'd0);
    chk({tag, "_cyc_ovf"}, 32'(bus.cyc_ovf), 32'd0);
    chk({tag, "_len_err"}, 32'(bus.len_err), 32'd0);
    chk({tag, "_w8_cycles"}, 32'(bus8.cycles), 32'd0);
`ifdef SD_READ_MONITOR_CHECKSUM_EN
    chk({tag, "_checksum"}, bus.checksum, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; start_s = 1'b0; fin_s = 1'b0; nb_s = '0; bv_s = 1'b0; bd_s = 8'h00;
    #12;
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Single block, strobes three cycles apart: 512*3 + 1 cycles.
    do_start(32'd1);
    for (int i = 0; i < 512; i++) begin
      strobe(8'h00);
      idle(2);
    end
    end_run(mk(512, 1, 1537, 1'b0, 1'b0, 0), mk(0, 128, 255, 1'b1, 1'b1, 0));
    idle(2);

    // Four blocks expected, one byte short.
    do_start(32'd4);
    for (int i = 0; i < 2047; i++) strobe(8'h00);
    end_run(mk(2047, 3, 2048, 1'b0, 1'b1, 0), mk(255, 255, 255, 1'b1, 1'b1, 0));
    idle(2);

    // Last byte coincides with finish; later strobes must not move results.
    do_start(32'd1);
    for (int i = 0; i < 511; i++) strobe(8'h00);
    bv_s = 1'b1;
    end_run(mk(512, 1, 512, 1'b0, 1'b0, 0), mk(0, 128, 255, 1'b1, 1'b1, 0));
    bv_s = 1'b0;
    for (int i = 0; i < 3; i++) strobe(8'hAA);
    chk("frozen_bytes",  bus.bytes,          32'd512);
    chk("frozen_blocks", bus.blocks,         32'd1);
    chk("frozen_cycles", bus.cycles,         32'd512);
    chk("frozen_done",   32'(bus.done),      32'd1);
    chk("frozen_w8_blk", 32'(bus8.blocks),   32'd128);
`ifdef SD_READ_MONITOR_CHECKSUM_EN
    chk("frozen_checksum", bus.checksum, 32'd0);
`endif

    // Asynchronous reset between edges mid-RUN, then finish with no start.
    do_start(32'd2);
    for (int i = 0; i < 10; i++) strobe(8'h00);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    fin_s = 1'b1;
    #3 rst = 1'b1;
    tick();
    idle(2);
    chk("post_rst_busy",   32'(bus.busy), 32'd0);
    chk("post_rst_done",   32'(bus.done), 32'd0);
    chk("post_rst_cycles", bus.cycles,    32'd0);
    fin_s = 1'b0;

    // n_blocks=0 with data, then back-to-back restart from DONE with no data.
    do_start(32'd0);
    for (int i = 0; i < 5; i++) strobe(8'h00);
    end_run(mk(5, 0, 6, 1'b0, 1'b1, 0), mk(5, 1, 6, 1'b0, 1'b1, 0));
    do_start(32'd0);
    chk("restart_busy",   32'(bus.busy),    32'd1);
    chk("restart_done",   32'(bus.done),    32'd0);
    chk("restart_bytes",  bus.bytes,        32'd0);
    chk("restart_cycles", bus.cycles,       32'd0);
    chk("restart_lerr",   32'(bus.len_err), 32'd0);
    end_run(mk(0, 0, 1, 1'b0, 1'b0, 0), mk(0, 0, 1, 1'b0, 1'b0, 0));

    // Exactly 255 cycles: the 8-bit counter is full but has not overflowed.
    do_start(32'd0);
    idle(254);
    end_run(mk(0, 0, 255, 1'b0, 1'b0, 0), mk(0, 0, 255, 1'b0, 1'b0, 0));

    // 301 cycles: the 8-bit counter saturates.
    do_start(32'd2);
    for (int i = 0; i < 8; i++) strobe(8'h00);
    idle(292);
    end_run(mk(8, 0, 301, 1'b0, 1'b1, 0), mk(8, 2, 255, 1'b1, 1'b0, 0));

    // Checksum over 01,02,03: 1, (1<<1)+2=4, (4<<1)+3=11.
    do_start(32'd0);
    strobe(8'h01);
    strobe(8'h02);
    strobe(8'h03);
    end_run(mk(3, 0, 4, 1'b0, 1'b1, 32'h0000_000B), mk(3, 0, 4, 1'b0, 1'b1, 32'h0000_000B));
    idle(3);

    chk("q32_drained", q32.size(), 32'd0);
    chk("q8_drained",  q8.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
